l15_req_arbiter: RTL and testbench
==================================

L15_REQ_ARBITER -- requirements
Module: l15_req_arbiter

Interface
- REQ-001: Parameter AddrWidth, default 64, physical request address width.
- REQ-002: Parameter DataWidth, default 64, store data width.
- REQ-003: Parameter MaxOutstandingStores, default 7, limit on unacknowledged stores.
- REQ-004: Parameter NrLoadBufEntries, default 2, limit on outstanding dcache loads.
- REQ-005: Parameter MemTidWidth, default 2, transaction ID width.
- REQ-006: The block has one clock and a synchronous, active-high reset; ports clk_i and rst_i.
- REQ-007: clk_i, in, 1, clock; all state updates on the rising edge.
- REQ-008: rst_i, in, 1, synchronous active-high reset.
- REQ-009: req_valid_i, in, 3, request per source: bit0 icache fill, bit1 dcache load, bit2 dcache store.
- REQ-010: req_addr_i, in, 3×AddrWidth, per-source address.
- REQ-011: req_data_i, in, DataWidth, store data; used for source 2 only.
- REQ-012: req_ready_o, out, 3, one-hot pulse on the cycle the source's request is captured.
- REQ-013: l15_val_o, out, 1, request valid toward L1.5.
- REQ-014: l15_rqtype_o, out, 2, request type: 0 ifill, 1 load, 2 store.
- REQ-015: l15_tid_o, l15_addr_o, l15_data_o, out, MemTidWidth / AddrWidth / DataWidth, captured payload.
- REQ-016: l15_ready_i, in, 1, L1.5 accepts the request when l15_val_o is also high.
- REQ-017: rtrn_valid_i, in, 1, and rtrn_type_i, in, 2, indicate a completion: 0 ifill return, 1 load return, 2 store ack.
- REQ-018: fence_i, in, 1, level drain request; fence_done_o, out, 1, drain-complete pulse.
- REQ-019: err_o, out, 1, sticky counter-underflow flag.

Function
- REQ-020: Counters: ic_cnt (0..1), ld_cnt (0..NrLoadBufEntries), st_cnt (0..MaxOutstandingStores).
- REQ-021: Eligibility: src0 requires ic_cnt==0; src1 requires ld_cnt<NrLoadBufEntries; src2 requires st_cnt<MaxOutstandingStores.
- REQ-022: The output register loads when state==RUN, (!l15_val_o || l15_ready_i), and at least one source is valid and eligible.
- REQ-023: Arbitration is round-robin: the search starts at rr_ptr, ascending mod 3; after a grant to source i, rr_ptr=(i+1) mod 3.
- REQ-024: On capture: req_ready_o[i]=1 that cycle; from the next cycle, l15_val_o=1 with l15_rqtype_o=i, addr=req_addr_i[i], data=req_data_i (src2) else 0, tid=tid_ctr.
- REQ-025: The matching counter and tid_ctr increment on capture; tid_ctr wraps modulo 2^MemTidWidth.
- REQ-026: Latency: a valid, eligible request at an idle output appears on l15_val_o exactly 1 cycle later.
- REQ-027: Throughput: if l15_ready_i=1 while l15_val_o=1, a new capture may occur in the same cycle, giving 1 request per cycle.
- REQ-028: If l15_val_o=1 and l15_ready_i=0, all l15_* outputs hold stable and no capture occurs.
- REQ-029: If l15_ready_i=1 and there is no capture, l15_val_o=0 next cycle.
- REQ-030: rtrn_valid_i decrements the counter selected by rtrn_type_i; type 3 is ignored.
- REQ-031: Capture and return hitting the same counter in the same cycle leave it unchanged.
- REQ-032: A return to a zero counter, with no same-cycle capture, leaves the counter at 0 and sets err_o; err_o clears only on reset.
- REQ-033: FSM states are RUN, DRAIN, DONE.
- REQ-034: RUN->DRAIN when fence_i=1; in DRAIN no new capture occurs, but a pending l15_val_o completes normally.
- REQ-035: DRAIN->DONE when l15_val_o==0 and all counters==0.
- REQ-036: DONE: fence_done_o=1 for exactly that cycle, then DONE->RUN if fence_i==0, else stay in DONE with fence_done_o=0.
- REQ-037: Sampling fence_i in RUN takes priority over capture in the same cycle.

Reset
- REQ-038: While rst_i=1 at the clock edge: state=RUN, counters=0, tid_ctr=0, rr_ptr=0, l15_val_o=0, l15_rqtype_o/tid/addr/data=0, req_ready_o=0, fence_done_o=0, err_o=0.
- REQ-039: Reset mid-transaction discards any pending l15 request and all counts, with no drain.

Verification
- REQ-040: All 3 valid continuously, l15_ready_i=1, returns immediate -> grants 0,1,2,0,1,2 in consecutive cycles; tids 0,1,2,3,0,1.
- REQ-041: Stores only, no acks -> exactly 7 captures; 8th held with req_ready_o[2]=0; one ack (type 2) -> 8th captured next cycle.
- REQ-042: l15_ready_i=0 for 5 cycles after capture -> l15_* stable for 5 cycles; src1 not granted during stall.
- REQ-043: Return type 1 with ld_cnt=1 in the same cycle as a src1 capture -> ld_cnt stays 1; return type 2 with st_cnt=0 -> err_o=1, st_cnt=0.
- REQ-044: fence_i=1 with ic_cnt=1, ld_cnt=2 -> no captures; after 3 returns fence_done_o pulses 1 cycle; fence_i low -> RUN.
- REQ-045: rst_i asserted with l15_val_o=1, st_cnt=4 -> next cycle all outputs 0, counters 0.

Source files
------------

// File: rtl/l15_req_arbiter.sv
// l15_req_arbiter
// Arbitrates icache fill, dcache load and dcache store requests onto a single
// registered L1.5 request channel. The arbiter is round-robin and tracks
// outstanding transactions per source, and it supports a fence/drain handshake.
//
// Ports
//   clk_i, rst_i     : clock, synchronous active-high reset
//   req_valid_i[2:0] : per-source request (0 ifill, 1 load, 2 store)
//   req_addr_i       : packed per-source addresses, source i at [i*AddrWidth +: AddrWidth]
//   req_data_i       : store data (source 2 only)
//   req_ready_o[2:0] : one-hot capture pulse, asserted in the capture cycle
//   l15_*_o          : registered request toward L1.5
//   l15_ready_i      : L1.5 accepts the request while l15_val_o is high
//   rtrn_valid_i/rtrn_type_i : completion (0 ifill, 1 load, 2 store ack, 3 ignored)
//   fence_i          : level drain request; fence_done_o pulses once drained
//   err_o            : sticky outstanding-counter underflow
module l15_req_arbiter #(
    parameter int unsigned AddrWidth            = 64,
    parameter int unsigned DataWidth            = 64,
    parameter int unsigned MaxOutstandingStores = 7,
    parameter int unsigned NrLoadBufEntries     = 2,
    parameter int unsigned MemTidWidth          = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [2:0]             req_valid_i,
    input  logic [3*AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0]   req_data_i,
    output logic [2:0]             req_ready_o,
    output logic                   l15_val_o,
    output logic [1:0]             l15_rqtype_o,
    output logic [MemTidWidth-1:0] l15_tid_o,
    output logic [AddrWidth-1:0]   l15_addr_o,
    output logic [DataWidth-1:0]   l15_data_o,
    input  logic                   l15_ready_i,
    input  logic                   rtrn_valid_i,
    input  logic [1:0]             rtrn_type_i,
    input  logic                   fence_i,
    output logic                   fence_done_o,
    output logic                   err_o
);

    localparam int unsigned LdW = $clog2(NrLoadBufEntries + 1);
    localparam int unsigned StW = $clog2(MaxOutstandingStores + 1);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

    state_e                 state_q, state_d;
    logic                   ic_cnt_q, ic_cnt_d;
    logic [LdW-1:0]         ld_cnt_q, ld_cnt_d;
    logic [StW-1:0]         st_cnt_q, st_cnt_d;
    logic [MemTidWidth-1:0] tid_ctr_q;
    logic [1:0]             rr_ptr_q;

    logic [2:0]             eligible;
    logic                   grant_valid;
    logic [1:0]             grant_idx;
    logic [2:0]             search_idx;
    logic                   capture;
    logic [AddrWidth-1:0]   grant_addr;
    logic [2:0]             cap_hit, ret_hit, underflow;

    // Round-robin search starting at rr_ptr_q.
    always_comb begin
        eligible[0] = req_valid_i[0] && !ic_cnt_q;
        eligible[1] = req_valid_i[1] && (ld_cnt_q < LdW'(NrLoadBufEntries));
        eligible[2] = req_valid_i[2] && (st_cnt_q < StW'(MaxOutstandingStores));
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        search_idx  = 3'd0;
        for (int unsigned k = 0; k < 3; k++) begin
            search_idx = {1'b0, rr_ptr_q} + 3'(k);
            if (search_idx >= 3'd3) search_idx = search_idx - 3'd3;
            if (!grant_valid && eligible[search_idx[1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = search_idx[1:0];
            end
        end
    end

    always_comb begin
        case (grant_idx)
            2'd0:    grant_addr = req_addr_i[0*AddrWidth +: AddrWidth];
            2'd1:    grant_addr = req_addr_i[1*AddrWidth +: AddrWidth];
            default: grant_addr = req_addr_i[2*AddrWidth +: AddrWidth];
        endcase
    end

    // A fence sampled in RUN blocks capture in that same cycle.
    always_comb begin
        state_d     = state_q;
        capture     = !rst_i && (state_q == RUN) && !fence_i &&
                      (!l15_val_o || l15_ready_i) && grant_valid;
        req_ready_o = '0;
        if (capture) req_ready_o[grant_idx] = 1'b1;
        case (state_q)
            RUN:     if (fence_i) state_d = DRAIN;
            DRAIN:   if (!l15_val_o && !ic_cnt_q && (ld_cnt_q == '0) && (st_cnt_q == '0))
                         state_d = DONE;
            DONE:    if (!fence_i) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Capture and return on the same counter cancel; a lone return at zero
    // saturates and flags underflow.
    always_comb begin
        cap_hit   = req_ready_o;
        ret_hit   = '0;
        underflow = '0;
        if (rtrn_valid_i && (rtrn_type_i != 2'd3)) ret_hit[rtrn_type_i] = 1'b1;

        ic_cnt_d = ic_cnt_q;
        if (cap_hit[0] && !ret_hit[0]) ic_cnt_d = 1'b1;
        else if (!cap_hit[0] && ret_hit[0]) begin
            if (!ic_cnt_q) underflow[0] = 1'b1;
            else           ic_cnt_d = 1'b0;
        end

        ld_cnt_d = ld_cnt_q;
        if (cap_hit[1] && !ret_hit[1]) ld_cnt_d = ld_cnt_q + 1'b1;
        else if (!cap_hit[1] && ret_hit[1]) begin
            if (ld_cnt_q == '0) underflow[1] = 1'b1;
            else                ld_cnt_d = ld_cnt_q - 1'b1;
        end

        st_cnt_d = st_cnt_q;
        if (cap_hit[2] && !ret_hit[2]) st_cnt_d = st_cnt_q + 1'b1;
        else if (!cap_hit[2] && ret_hit[2]) begin
            if (st_cnt_q == '0) underflow[2] = 1'b1;
            else                st_cnt_d = st_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            ic_cnt_q     <= 1'b0;
            ld_cnt_q     <= '0;
            st_cnt_q     <= '0;
            tid_ctr_q    <= '0;
            rr_ptr_q     <= 2'd0;
            l15_val_o    <= 1'b0;
            l15_rqtype_o <= 2'd0;
            l15_tid_o    <= '0;
            l15_addr_o   <= '0;
            l15_data_o   <= '0;
            fence_done_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ic_cnt_q     <= ic_cnt_d;
            ld_cnt_q     <= ld_cnt_d;
            st_cnt_q     <= st_cnt_d;
            err_o        <= err_o || (underflow != '0);
            fence_done_o <= (state_q == DRAIN) && (state_d == DONE);
            if (capture) begin
                l15_val_o    <= 1'b1;
                l15_rqtype_o <= grant_idx;
                l15_tid_o    <= tid_ctr_q;
                l15_addr_o   <= grant_addr;
                l15_data_o   <= (grant_idx == 2'd2) ? req_data_i : '0;
                tid_ctr_q    <= tid_ctr_q + 1'b1;
                rr_ptr_q     <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
            end else if (l15_ready_i) begin
                l15_val_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_l15_req_arbiter.sv
module tb_l15_req_arbiter;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [2:0]   req_valid_i;
    logic [191:0] req_addr_i;
    logic [63:0]  req_data_i;
    logic [2:0]   req_ready_o;
    logic         l15_val_o;
    logic [1:0]   l15_rqtype_o;
    logic [1:0]   l15_tid_o;
    logic [63:0]  l15_addr_o;
    logic [63:0]  l15_data_o;
    logic         l15_ready_i;
    logic         rtrn_valid_i;
    logic [1:0]   rtrn_type_i;
    logic         fence_i;
    logic         fence_done_o;
    logic         err_o;

    always #5 clk_i = ~clk_i;

    l15_req_arbiter #(
        .AddrWidth(64), .DataWidth(64), .MaxOutstandingStores(7),
        .NrLoadBufEntries(2), .MemTidWidth(2)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
        .l15_val_o(l15_val_o), .l15_rqtype_o(l15_rqtype_o), .l15_tid_o(l15_tid_o),
        .l15_addr_o(l15_addr_o), .l15_data_o(l15_data_o), .l15_ready_i(l15_ready_i),
        .rtrn_valid_i(rtrn_valid_i), .rtrn_type_i(rtrn_type_i), .fence_i(fence_i),
        .fence_done_o(fence_done_o), .err_o(err_o)
    );

    typedef struct {
        logic [2:0] valid;
        logic       rdy;
        logic       rv;
        logic [1:0] rt;
        logic       fence;
        logic [2:0] exp_ready;
        logic       exp_val;
        logic [1:0] exp_type;
        logic [1:0] exp_tid;
        logic       exp_err;
        logic       exp_done;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] addr_tab[3];
    logic [63:0] store_data;
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic vec_t mk(logic [2:0] valid, logic rdy, logic rv, logic [1:0] rt,
                                logic fence, logic [2:0] er, logic ev, logic [1:0] et,
                                logic [1:0] etid, logic eerr, logic edone);
        vec_t v;
        v.valid = valid; v.rdy = rdy; v.rv = rv; v.rt = rt; v.fence = fence;
        v.exp_ready = er; v.exp_val = ev; v.exp_type = et; v.exp_tid = etid;
        v.exp_err = eerr; v.exp_done = edone;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] valid, input logic rdy, input logic rv,
                         input logic [1:0] rt, input logic fence);
        req_valid_i  = valid;
        l15_ready_i  = rdy;
        rtrn_valid_i = rv;
        rtrn_type_i  = rt;
        fence_i      = fence;
    endtask

    initial begin
        addr_tab[0] = 64'h0000_1000_0000_0040;
        addr_tab[1] = 64'h0000_2000_0000_0080;
        addr_tab[2] = 64'h0000_3000_0000_00c0;
        store_data  = 64'hdead_beef_cafe_f00d;
        req_addr_i  = {addr_tab[2], addr_tab[1], addr_tab[0]};
        req_data_i  = store_data;

        // Round-robin with immediate returns: grants 0,1,2,0,1,2 / tids 0..3,0,1
        vecs.push_back(mk(3'b111,1,0,0,0, 3'b001,1,0,0,0,0));
        vecs.push_back(mk(3'b111,1,1,0,0, 3'b010,1,1,1,0,0));
        vecs.push_back(mk(3'b111,1,1,1,0, 3'b100,1,2,2,0,0));
        vecs.push_back(mk(3'b111,1,1,2,0, 3'b001,1,0,3,0,0));
        vecs.push_back(mk(3'b111,1,1,0,0, 3'b010,1,1,0,0,0));
        vecs.push_back(mk(3'b111,1,1,1,0, 3'b100,1,2,1,0,0));
        vecs.push_back(mk(3'b000,1,1,2,0, 3'b000,0,0,0,0,0));
        // Load capture then 5-cycle stall with src1 still requesting
        vecs.push_back(mk(3'b010,0,0,0,0, 3'b010,1,1,2,0,0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(3'b011,0,0,0,0, 3'b000,1,1,2,0,0));
        vecs.push_back(mk(3'b000,1,0,0,0, 3'b000,0,0,0,0,0));
        // Same-cycle load return + capture keeps ld_cnt at 1; then fill to 2
        vecs.push_back(mk(3'b010,1,1,1,0, 3'b010,1,1,3,0,0));
        vecs.push_back(mk(3'b010,1,0,0,0, 3'b010,1,1,0,0,0));
        vecs.push_back(mk(3'b010,1,0,0,0, 3'b000,0,0,0,0,0));
        // Store ack with st_cnt=0 -> sticky err
        vecs.push_back(mk(3'b000,1,1,2,0, 3'b000,0,0,0,1,0));
        // ic fill so ic_cnt=1, ld_cnt=2
        vecs.push_back(mk(3'b001,1,0,0,0, 3'b001,1,0,1,1,0));
        // Fence: drain pending output, three returns, done pulse, back to RUN
        vecs.push_back(mk(3'b111,1,0,0,1, 3'b000,0,0,0,1,0));
        vecs.push_back(mk(3'b111,1,1,0,1, 3'b000,0,0,0,1,0));
        vecs.push_back(mk(3'b111,1,1,1,1, 3'b000,0,0,0,1,0));
        vecs.push_back(mk(3'b111,1,1,1,1, 3'b000,0,0,0,1,0));
        vecs.push_back(mk(3'b111,1,0,0,1, 3'b000,0,0,0,1,1));
        vecs.push_back(mk(3'b111,1,0,0,1, 3'b000,0,0,0,1,0));
        vecs.push_back(mk(3'b111,1,0,0,0, 3'b000,0,0,0,1,0));
        vecs.push_back(mk(3'b111,1,0,0,0, 3'b010,1,1,2,1,0));
        vecs.push_back(mk(3'b000,1,1,1,0, 3'b000,0,0,0,1,0));
        // Stores without acks: 7 captures, 8th held until one ack
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(3'b100,1,0,0,0, 3'b100,1,2,2'((3 + i) % 4),1,0));
        vecs.push_back(mk(3'b100,1,0,0,0, 3'b000,0,0,0,1,0));
        vecs.push_back(mk(3'b100,1,1,2,0, 3'b000,0,0,0,1,0));
        vecs.push_back(mk(3'b100,1,0,0,0, 3'b100,1,2,2,1,0));
        // Stalled store while acks bring st_cnt down to 4
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(3'b000,0,1,2,0, 3'b000,1,2,2,1,0));

        rst_i = 1'b1;
        drive(3'b000, 1'b0, 1'b0, 2'd0, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_val", 64'(l15_val_o), 64'd0);
        check("rst_ready", 64'(req_ready_o), 64'd0);
        check("rst_tid", 64'(l15_tid_o), 64'd0);
        check("rst_addr", l15_addr_o, 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_done", 64'(fence_done_o), 64'd0);

        @(negedge clk_i);
        rst_i = 1'b0;
        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk_i);
            drive(vecs[i].valid, vecs[i].rdy, vecs[i].rv, vecs[i].rt, vecs[i].fence);
            #1;
            check($sformatf("v%0d_ready", i), 64'(req_ready_o), 64'(vecs[i].exp_ready));
            @(posedge clk_i);
            #1;
            check($sformatf("v%0d_val", i), 64'(l15_val_o), 64'(vecs[i].exp_val));
            check($sformatf("v%0d_err", i), 64'(err_o), 64'(vecs[i].exp_err));
            check($sformatf("v%0d_done", i), 64'(fence_done_o), 64'(vecs[i].exp_done));
            if (vecs[i].exp_val) begin
                check($sformatf("v%0d_type", i), 64'(l15_rqtype_o), 64'(vecs[i].exp_type));
                check($sformatf("v%0d_tid", i), 64'(l15_tid_o), 64'(vecs[i].exp_tid));
                check($sformatf("v%0d_addr", i), l15_addr_o, addr_tab[vecs[i].exp_type]);
                check($sformatf("v%0d_data", i), l15_data_o,
                      (vecs[i].exp_type == 2'd2) ? store_data : 64'd0);
            end
        end

        // Reset mid-transaction: l15_val_o=1, st_cnt=4, err set
        @(negedge clk_i);
        rst_i = 1'b1;
        drive(3'b111, 1'b0, 1'b0, 2'd0, 1'b0);
        #1;
        check("mrst_ready", 64'(req_ready_o), 64'd0);
        @(posedge clk_i);
        #1;
        check("mrst_val", 64'(l15_val_o), 64'd0);
        check("mrst_type", 64'(l15_rqtype_o), 64'd0);
        check("mrst_tid", 64'(l15_tid_o), 64'd0);
        check("mrst_addr", l15_addr_o, 64'd0);
        check("mrst_data", l15_data_o, 64'd0);
        check("mrst_err", 64'(err_o), 64'd0);
        check("mrst_done", 64'(fence_done_o), 64'd0);

        // st_cnt and tid_ctr must restart at 0: seven stores accepted, eighth held
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k != 0) @(negedge clk_i);
            drive(3'b100, 1'b1, 1'b0, 2'd0, 1'b0);
            #1;
            check($sformatf("post_rst_ready%0d", k), 64'(req_ready_o),
                  (k < 7) ? 64'd4 : 64'd0);
            @(posedge clk_i);
            #1;
            check($sformatf("post_rst_val%0d", k), 64'(l15_val_o), (k < 7) ? 64'd1 : 64'd0);
            if (k < 7) check($sformatf("post_rst_tid%0d", k), 64'(l15_tid_o), 64'(k % 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
